shot_sequencer: RTL
===================

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter POWER_MIN, default 16, power loaded when charging starts.
REQ-002 Parameter POWER_MAX, default 255, saturation ceiling of power.
REQ-003 Parameter POWER_STEP, default 4, power increment per frame while charging.
REQ-004 Parameter SETTLE_FRAMES, default 8, consecutive still frames that end a shot.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 resetN  input  1  reset; asynchronous, active-low.
REQ-007 startOfFrame  input  1  one-cycle pulse per video frame; the block's timebase.
REQ-008 shootKey  input  1  level; player holds to charge and releases to fire.
REQ-009 ballsMoving  input  1  level; 1 while any ball has nonzero velocity.
REQ-010 ballPocketed  input  1  one-cycle pulse; current player potted an object ball.
REQ-011 foul  input  1  one-cycle pulse; cue ball pocketed or other foul.
REQ-012 power  output  32 (int)  shot strength to the cue velocity datapath, 0..POWER_MAX.
REQ-013 shoot  output  1  one-cycle fire pulse to the cue velocity datapath.
REQ-014 cueVisible  output  1  1 when the cue is drawn and aimable.
REQ-015 player  output  1  current player, 0 or 1.
REQ-016 turnPulse  output  1  one-cycle pulse at each end of shot.
REQ-017 state  output  3  current state encoding for debug/display: AIM=0, CHARGE=1, FIRE=2, ROLLING=3, TURN=4.

Function
REQ-018 The block SHALL register shootKey once per clk (keyD) and SHALL define a keyRise as shootKey=1 and keyD=0.
REQ-019 In AIM, cueVisible=1; a keyRise with ballsMoving=0 SHALL move to CHARGE and load power=POWER_MIN; a keyRise with ballsMoving=1 SHALL be ignored.
REQ-020 In CHARGE, each startOfFrame with shootKey=1 SHALL add POWER_STEP to power, saturating at POWER_MAX.
REQ-021 In CHARGE, shootKey=0 SHALL move to FIRE on the next edge; if startOfFrame coincides, power SHALL NOT increment.
REQ-022 FIRE SHALL last exactly one cycle, with shoot=1 only in that cycle, then move to ROLLING.
REQ-023 power SHALL hold its value from FIRE through TURN and SHALL be 0 in AIM.
REQ-024 In ROLLING, cueVisible=0 and a still counter SHALL increment on each startOfFrame with ballsMoving=0 and clear on any cycle with ballsMoving=1.
REQ-025 ROLLING SHALL move to TURN on the edge where the still counter reaches SETTLE_FRAMES.
REQ-026 During ROLLING, ballPocketed SHALL set a sticky potFlag and foul SHALL set a sticky foulFlag; pulses outside ROLLING SHALL be ignored.
REQ-027 TURN SHALL last one cycle with turnPulse=1; player SHALL toggle if foulFlag=1 or potFlag=0, else be kept.
REQ-028 If foul and ballPocketed arrive in the same cycle, both flags SHALL set and foul SHALL take precedence (player toggles).
REQ-029 On leaving TURN, the block SHALL clear both flags, the still counter and power, then enter AIM.
REQ-030 A shootKey held continuously from CHARGE through TURN SHALL NOT start a new charge; a fresh keyRise is required.
REQ-031 shoot, turnPulse, cueVisible and state SHALL be registered or decoded from registered state only, never from inputs directly.

Reset
REQ-032 resetN=0 SHALL immediately force state=AIM, power=0, shoot=0, turnPulse=0, player=0, cueVisible=1, and clear keyD, flags and still counter, including mid-CHARGE or mid-ROLLING.
REQ-033 After resetN deasserts, a shootKey already held SHALL NOT trigger CHARGE until released and pressed again.

Verification
REQ-034 Press shootKey, hold 10 startOfFrame pulses, release -> power=56, one shoot pulse one cycle after release sampled, cueVisible=0 thereafter.
REQ-035 Hold shootKey for 100 frames -> power saturates at 255 and stays 255 through FIRE.
REQ-036 After shoot, ballsMoving=1 for 20 frames then 0 -> turnPulse exactly 8 frames after ballsMoving falls; player toggles 0->1; power=0 in AIM.
REQ-037 ballPocketed pulse during ROLLING, no foul -> player unchanged at TURN; ballPocketed and foul same cycle -> player toggles.
REQ-038 Assert resetN=0 mid-CHARGE with power=40 -> power=0, state=AIM, player=0 without a clock edge; held key gives no charge until re-pressed.
REQ-039 keyRise in AIM with ballsMoving=1 -> state stays AIM, power stays 0, no shoot.

Source files
------------

// File: rtl/shot_sequencer_if.sv
// Frame-timed game-control signals between the table logic and the shot sequencer.
// The master side drives the player/physics inputs; the slave side is the sequencer.
interface shot_sequencer_if;
    logic        startOfFrame;
    logic        shootKey;
    logic        ballsMoving;
    logic        ballPocketed;
    logic        foul;
    logic [31:0] power;
    logic        shoot;
    logic        cueVisible;
    logic        player;
    logic        turnPulse;
    logic [2:0]  state;

    modport master (
        output startOfFrame, shootKey, ballsMoving, ballPocketed, foul,
        input  power, shoot, cueVisible, player, turnPulse, state
    );

    modport slave (
        input  startOfFrame, shootKey, ballsMoving, ballPocketed, foul,
        output power, shoot, cueVisible, player, turnPulse, state
    );
endinterface

// File: rtl/shot_sequencer.sv
// Shot sequencer for a two-player pool game: charges cue power while the key is
// held, fires on release, waits for the table to settle, then hands the turn over.
module shot_sequencer #(
    parameter int POWER_MIN     = 16,
    parameter int POWER_MAX     = 255,
    parameter int POWER_STEP    = 4,
    parameter int SETTLE_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    shot_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_AIM     = 3'd0,
        ST_CHARGE  = 3'd1,
        ST_FIRE    = 3'd2,
        ST_ROLLING = 3'd3,
        ST_TURN    = 3'd4
    } state_e;

    localparam int               CNT_W       = $clog2(SETTLE_FRAMES + 1);
    localparam logic [31:0]      P_MIN       = 32'(POWER_MIN);
    localparam logic [31:0]      P_MAX       = 32'(POWER_MAX);
    localparam logic [31:0]      P_STEP      = 32'(POWER_STEP);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] SETTLE_FULL = CNT_W'(SETTLE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] ceil
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, ceil}) begin
            sat_add = ceil;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

    state_e            state_r, state_s;
    logic [31:0]       power_r, power_s;
    logic [CNT_W-1:0]  still_r, still_s;
    logic              pot_r, pot_s;
    logic              foul_r, foul_s;
    logic              player_r, player_s;
    logic              key_d_r;
    logic              key_armed_r;
    logic              key_rise_s;
    logic              shoot_r;
    logic              turn_r;
    logic              cue_r;

    // A key already held when reset lifts must be released once before it can arm a charge.
    assign key_rise_s = bus.shootKey & ~key_d_r & key_armed_r;

    // Next-state, power, settle counter, flags and turn-owner decisions.
    always_comb begin
        state_s  = state_r;
        power_s  = power_r;
        still_s  = still_r;
        pot_s    = pot_r;
        foul_s   = foul_r;
        player_s = player_r;
        case (state_r)
            ST_AIM: begin
                power_s = 32'd0;
                if (key_rise_s && !bus.ballsMoving) begin
                    state_s = ST_CHARGE;
                    power_s = P_MIN;
                end else begin
                    state_s = ST_AIM;
                end
            end
            ST_CHARGE: begin
                // Release wins over a coincident frame tick: the power is frozen as-is.
                if (!bus.shootKey) begin
                    state_s = ST_FIRE;
                end else if (bus.startOfFrame) begin
                    power_s = sat_add(power_r, P_STEP, P_MAX);
                end else begin
                    power_s = power_r;
                end
            end
            ST_FIRE: begin
                state_s = ST_ROLLING;
            end
            ST_ROLLING: begin
                if (bus.ballPocketed) begin
                    pot_s = 1'b1;
                end else begin
                    pot_s = pot_r;
                end
                if (bus.foul) begin
                    foul_s = 1'b1;
                end else begin
                    foul_s = foul_r;
                end
                if (bus.ballsMoving) begin
                    still_s = CNT_ZERO;
                end else if (bus.startOfFrame) begin
                    if (still_r == SETTLE_LAST) begin
                        still_s = SETTLE_FULL;
                        state_s = ST_TURN;
                    end else begin
                        still_s = still_r + CNT_ONE;
                    end
                end else begin
                    still_s = still_r;
                end
            end
            ST_TURN: begin
                // A foul hands over the table even if a ball was potted.
                if (foul_r || !pot_r) begin
                    player_s = ~player_r;
                end else begin
                    player_s = player_r;
                end
                state_s = ST_AIM;
                power_s = 32'd0;
                still_s = CNT_ZERO;
                pot_s   = 1'b0;
                foul_s  = 1'b0;
            end
            default: begin
                state_s = ST_AIM;
                power_s = 32'd0;
                still_s = CNT_ZERO;
                pot_s   = 1'b0;
                foul_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_AIM;
            power_r     <= 32'd0;
            still_r     <= CNT_ZERO;
            pot_r       <= 1'b0;
            foul_r      <= 1'b0;
            player_r    <= 1'b0;
            key_d_r     <= 1'b0;
            key_armed_r <= 1'b0;
            shoot_r     <= 1'b0;
            turn_r      <= 1'b0;
            cue_r       <= 1'b1;
        end else begin
            state_r     <= state_s;
            power_r     <= power_s;
            still_r     <= still_s;
            pot_r       <= pot_s;
            foul_r      <= foul_s;
            player_r    <= player_s;
            key_d_r     <= bus.shootKey;
            key_armed_r <= key_armed_r | ~bus.shootKey;
            shoot_r     <= (state_s == ST_FIRE);
            turn_r      <= (state_s == ST_TURN);
            cue_r       <= (state_s == ST_AIM) || (state_s == ST_CHARGE);
        end
    end

    assign bus.power      = power_r;
    assign bus.shoot      = shoot_r;
    assign bus.cueVisible = cue_r;
    assign bus.player     = player_r;
    assign bus.turnPulse  = turn_r;
    assign bus.state      = state_r;

endmodule
